// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device transmitter (inhibit, start, 8 data, odd parity, stop, ACK).
// Define PS2_TX_RETRY_EN to retransmit the latched byte up to MAX_RETRY extra times before flagging tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          data_meta_q, data_sync_q;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          fall;
    logic          final_fail;

    // Bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [RW-1:0] retry_cnt_q, retry_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (state_q == S_IDLE && tx_valid) begin
            retry_cnt_d = '0;
        end else if (state_q == S_FAIL && retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
        end
    end

    assign final_fail = (retry_cnt_q >= RETRY_MAX);
`else
    logic unused_max_retry;
    assign unused_max_retry = (MAX_RETRY != 0);
    assign final_fail       = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end

            // Clock falls seen here are our own inhibit pulse and are ignored.
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    bit_idx_d = '0;
                    state_d   = S_SEND;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            S_SEND: begin
                if (to_cnt_q == TO_LAST) begin
                    data_oe_d = 1'b0;
                    state_d   = S_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall) begin
                        data_oe_d = ~shift_q[bit_idx_q];
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end

            S_ACK: begin
                if (to_cnt_q == TO_LAST) begin
                    data_oe_d = 1'b0;
                    state_d   = S_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall) begin
                        state_d = data_sync_q ? S_FAIL : S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_FAIL: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
`ifdef PS2_TX_RETRY_EN
                if (!final_fail) begin
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
`endif
            end

            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign tx_done     = done_q;
    assign tx_err      = (state_q == S_FAIL) && final_fail;
    assign ps2_clk_oe  = (state_q == S_INHIBIT);
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + randomized bench for ps2_host_tx with an open-drain PS/2 device model on the bus.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 5000;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       bus_clk, bus_data;

    assign bus_clk  = dev_clk & ~ps2_clk_oe;
    assign bus_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (bus_clk),
        .ps2_data_in(bus_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   inh_run = 0, inh_len = 0;
    int   send_cnt = 0, send_cyc = 0, send_consumed = 0;
    int   acc_cnt = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, inv_viol = 0;
    logic prev_clk_oe = 1'b0, prev_busy = 1'b0;
    int   vectors = 0, miscompares = 0;
    logic [9:0] rx_bits;
    bit   rx_got;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer: inhibit length, SEND entries, accepts, pulses and invariants.
    always @(negedge clk) begin
        prev_clk_oe <= ps2_clk_oe;
        prev_busy   <= busy;
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (prev_clk_oe) begin
            inh_len  <= inh_run;
            inh_run  <= 0;
            send_cnt <= send_cnt + 1;
            send_cyc <= cyc;
        end
        if (busy && !prev_busy) acc_cnt <= acc_cnt + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if ((tx_done && tx_err) || (ps2_clk_oe && ps2_data_oe) || (tx_ready == busy))
            inv_viol <= inv_viol + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: data LSB first, odd parity bit, stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b};
    endfunction

    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic dev_rx(input int nclk, input bit ack, input int half,
                          output logic [9:0] bits, output bit got);
        int n;
        n    = 0;
        got  = 1'b0;
        bits = '0;
        while (send_cnt <= send_consumed && n < 30000) begin
            @(negedge clk); #1; n++;
        end
        if (send_cnt <= send_consumed) begin
            check("send_entry", 32'(0), 32'(1));
            return;
        end
        send_consumed++;
        got = 1'b1;
        check("start_bit", 32'(ps2_data_oe), 32'(1));
        repeat (half) @(negedge clk);
        for (int i = 0; i < 10 && i < nclk; i++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = bus_data;
            repeat (half) @(negedge clk);
        end
        if (nclk >= 11) begin
            if (ack) dev_data = 1'b0;
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            dev_clk = 1'b1;
            repeat (4) @(negedge clk);
            dev_data = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 32'(tx_ready), 32'(1));
    endtask

    task automatic wait_err(input int e_before, input int bound);
        int n;
        n = 0;
        while (err_cnt == e_before && n < bound) begin
            @(negedge clk); #1; n++;
        end
        check("err_pulse", 32'(err_cnt - e_before), 32'(1));
    endtask

    task automatic do_xfer(input logic [7:0] b, input int half, input string tag);
        int d0, e0, a0;
        d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
        send_req(b);
        dev_rx(11, 1'b1, half, rx_bits, rx_got);
        wait_idle({tag, "_idle"});
        check({tag, "_frame"}, 32'(rx_bits), 32'(frame_of(b)));
        check({tag, "_inhibit"}, 32'(inh_len), 32'(INH));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'(1));
        check({tag, "_err"}, 32'(err_cnt - e0), 32'(0));
        check({tag, "_accepts"}, 32'(acc_cnt - a0), 32'(1));
    endtask

    initial begin
        int d0, e0, a0, s0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(tx_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(tx_done), 32'(0));
        check("rst_err", 32'(tx_err), 32'(0));
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'(0));
        check("rst_data_oe", 32'(ps2_data_oe), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: 0xED acknowledged
        do_xfer(8'hED, 30, "t1");
        check("t1_const", 32'(rx_bits), 32'h3ED);

        // 2: 0x00 then 0x01 with tx_valid held high throughout
        d0 = done_cnt; a0 = acc_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_data = 8'h01;
        repeat (50) @(negedge clk);
        #1;
        check("t2_one_accept", 32'(acc_cnt - a0), 32'(1));
        dev_rx(11, 1'b1, 30, rx_bits, rx_got);
        check("t2_frame0", 32'(rx_bits), 32'h300);
        @(negedge clk);
        tx_valid = 1'b0;
        #1;
        check("t2_two_accepts", 32'(acc_cnt - a0), 32'(2));
        check("t2_first_done", 32'(done_cnt - d0), 32'(1));
        dev_rx(11, 1'b1, 35, rx_bits, rx_got);
        wait_idle("t2_idle");
        check("t2_frame1", 32'(rx_bits), 32'h201);
        check("t2_done", 32'(done_cnt - d0), 32'(2));

        // 3: NACK on every attempt
        d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt; s0 = send_cnt;
        b = 8'($urandom);
        send_req(b);
        for (int k = 0; k < ATTEMPTS; k++) begin
            dev_rx(11, 1'b0, 30, rx_bits, rx_got);
            check("t3_frame", 32'(rx_bits), 32'(frame_of(b)));
        end
        wait_err(e0, 2000);
        check("t3_clk_oe", 32'(ps2_clk_oe), 32'(0));
        check("t3_data_oe", 32'(ps2_data_oe), 32'(0));
        wait_idle("t3_idle");
        repeat (5) @(negedge clk);
        #1;
        check("t3_attempts", 32'(send_cnt - s0), 32'(ATTEMPTS));
        check("t3_err_once", 32'(err_cnt - e0), 32'(1));
        check("t3_no_done", 32'(done_cnt - d0), 32'(0));
        check("t3_accepts", 32'(acc_cnt - a0), 32'(1));

        // 4: device never clocks
        d0 = done_cnt; e0 = err_cnt; s0 = send_cnt;
        send_req(8'($urandom));
        wait_err(e0, 20000);
        check("t4_latency", 32'(err_cyc - send_cyc), 32'(TMO));
        @(negedge clk);
        #1;
        check("t4_ready", 32'(tx_ready), 32'(1));
        check("t4_attempts", 32'(send_cnt - s0), 32'(ATTEMPTS));
        check("t4_no_done", 32'(done_cnt - d0), 32'(0));
        send_consumed = send_cnt;

        // 5: request pulsed mid-transfer is ignored
        d0 = done_cnt; a0 = acc_cnt;
        b = 8'h5C;
        send_req(b);
        fork
            dev_rx(11, 1'b1, 30, rx_bits, rx_got);
            begin
                repeat (120) @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = 8'hAA;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_idle("t5_idle");
        check("t5_frame", 32'(rx_bits), 32'(frame_of(b)));
        check("t5_accepts", 32'(acc_cnt - a0), 32'(1));
        check("t5_done", 32'(done_cnt - d0), 32'(1));

        // 6: reset after 4th data bit
        b = 8'($urandom) & 8'hF7;
        send_req(b);
        dev_rx(4, 1'b1, 30, rx_bits, rx_got);
        #1;
        check("t6_bit3_driven", 32'(ps2_data_oe), 32'(1));
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        #1;
        check("t6_clk_oe", 32'(ps2_clk_oe), 32'(0));
        check("t6_data_oe", 32'(ps2_data_oe), 32'(0));
        check("t6_ready", 32'(tx_ready), 32'(1));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt - d0), 32'(0));
        check("t6_no_err", 32'(err_cnt - e0), 32'(0));
        do_xfer(8'hFF, 28, "t6_ff");

        // Randomized bytes and device clock rates
        for (int k = 0; k < 4; k++) begin
            do_xfer(8'($urandom), int'($urandom_range(25, 40)), "rnd");
        end

        check("invariants", 32'(inv_viol), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
